// File: rtl/reorder_commit_buffer.sv
// reorder_commit_buffer: in-order retirement buffer feeding register-file write-back.
// Instructions are dispatched at the tail, completed out of order by tag, and
// retired from the head at most one per cycle onto the wb_* port.
// Optional build macro: ROB_BYPASS_EN -- a completion aimed at the head entry
// retires on the same edge, using complete_data directly.
module reorder_commit_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int PREG_WIDTH = 6,
  parameter int AL_WIDTH   = 5,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  output logic                  dispatch_ready,
  input  logic                  dispatch_rw,
  input  logic [PREG_WIDTH-1:0] dispatch_preg,
  input  logic [AL_WIDTH-1:0]   dispatch_al_index,
  output logic [TAG_WIDTH-1:0]  dispatch_tag,
  input  logic                  complete_valid,
  input  logic [TAG_WIDTH-1:0]  complete_tag,
  input  logic [DATA_WIDTH-1:0] complete_data,
  output logic                  wb_write_enable,
  output logic [PREG_WIDTH-1:0] wb_physical_write_addr,
  output logic [DATA_WIDTH-1:0] wb_physical_write_data,
  output logic [AL_WIDTH-1:0]   wb_active_list_index,
  output logic [TAG_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << TAG_WIDTH;

  // Control state (reset)
  logic [TAG_WIDTH-1:0]  head_q, head_d;
  logic [TAG_WIDTH-1:0]  tail_q, tail_d;
  logic [TAG_WIDTH:0]    count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      done_q, done_d;

  // Write-back port registers
  logic                  wb_we_q, wb_we_d;
  logic [PREG_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [AL_WIDTH-1:0]   wb_al_q, wb_al_d;

  // Entry payload (only read while the entry is valid, so no reset needed)
  logic                  rw_q   [DEPTH];
  logic [PREG_WIDTH-1:0] preg_q [DEPTH];
  logic [AL_WIDTH-1:0]   al_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic                  dispatch_fire;
  logic                  complete_hit;
  logic                  bypass;
  logic                  retire;
  logic [DATA_WIDTH-1:0] retire_data;

  assign full           = (count_q == (TAG_WIDTH+1)'(DEPTH));
  assign empty          = (count_q == '0);
  assign count          = count_q;
  assign dispatch_ready = !full && !flush;
  assign dispatch_tag   = tail_q;

  assign wb_write_enable        = wb_we_q;
  assign wb_physical_write_addr = wb_addr_q;
  assign wb_physical_write_data = wb_data_q;
  assign wb_active_list_index   = wb_al_q;

  // Handshake decode and retire decision from registered entry state
  always_comb begin
    dispatch_fire = dispatch_valid && dispatch_ready;
    complete_hit  = complete_valid && valid_q[complete_tag];
`ifdef ROB_BYPASS_EN
    bypass = complete_valid && (complete_tag == head_q) &&
             valid_q[head_q] && !done_q[head_q];
`else
    bypass = 1'b0;
`endif
    retire      = valid_q[head_q] && (done_q[head_q] || bypass);
    retire_data = bypass ? complete_data : data_q[head_q];
  end

  // Next-state: pointers, occupancy, per-entry flags and write-back port
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    valid_d   = valid_q;
    done_d    = done_q;
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_al_d   = wb_al_q;
    if (flush) begin
      // Flush wins over everything else happening on this edge
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (complete_hit) begin
        done_d[complete_tag] = 1'b1;
      end
      if (dispatch_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = !dispatch_rw;
        tail_d          = tail_q + 1'b1;
      end
      if (retire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
        wb_we_d         = rw_q[head_q] && (preg_q[head_q] != '0);
        wb_addr_d       = preg_q[head_q];
        wb_data_d       = retire_data;
        wb_al_d         = al_q[head_q];
      end
      case ({dispatch_fire, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and write-back registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_al_q   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_al_q   <= wb_al_d;
    end
  end

  // Payload capture: dispatch fills the tail entry, completion writes result data.
  // A dispatch target is always invalid, so it never collides with a completion hit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (dispatch_fire && (tail_q == TAG_WIDTH'(i))) begin
        rw_q[i]   <= dispatch_rw;
        preg_q[i] <= dispatch_preg;
        al_q[i]   <= dispatch_al_index;
        data_q[i] <= '0;
      end else if (complete_hit && (complete_tag == TAG_WIDTH'(i))) begin
        data_q[i] <= complete_data;
      end
    end
  end

endmodule

// File: tb/tb_reorder_commit_buffer.sv
// Directed self-checking bench for reorder_commit_buffer (default build, no bypass).
module tb_reorder_commit_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic        dispatch_rw;
  logic [5:0]  dispatch_preg;
  logic [4:0]  dispatch_al_index;
  logic [3:0]  dispatch_tag;
  logic        complete_valid;
  logic [3:0]  complete_tag;
  logic [31:0] complete_data;
  logic        wb_write_enable;
  logic [5:0]  wb_physical_write_addr;
  logic [31:0] wb_physical_write_data;
  logic [4:0]  wb_active_list_index;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  int checks   = 0;
  int failures = 0;

  // Record of every observed write-back strobe (al index and address)
  logic [4:0] wb_al_log[$];
  logic [5:0] wb_addr_log[$];
  // Record of every retirement seen with the strobe low
  int         quiet_retires;

  reorder_commit_buffer dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .flush                  (flush),
    .dispatch_valid         (dispatch_valid),
    .dispatch_ready         (dispatch_ready),
    .dispatch_rw            (dispatch_rw),
    .dispatch_preg          (dispatch_preg),
    .dispatch_al_index      (dispatch_al_index),
    .dispatch_tag           (dispatch_tag),
    .complete_valid         (complete_valid),
    .complete_tag           (complete_tag),
    .complete_data          (complete_data),
    .wb_write_enable        (wb_write_enable),
    .wb_physical_write_addr (wb_physical_write_addr),
    .wb_physical_write_data (wb_physical_write_data),
    .wb_active_list_index   (wb_active_list_index),
    .count                  (count),
    .empty                  (empty),
    .full                   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_write_enable === 1'b1) begin
      wb_al_log.push_back(wb_active_list_index);
      wb_addr_log.push_back(wb_physical_write_addr);
    end
  endtask

  task automatic do_reset();
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    complete_valid = 1'b0;
    rst_n          = 1'b0;
    #3;
    rst_n          = 1'b1;
  endtask

  task automatic disp(input logic rw, input logic [5:0] p, input logic [4:0] a);
    dispatch_valid    = 1'b1;
    dispatch_rw       = rw;
    dispatch_preg     = p;
    dispatch_al_index = a;
    tick();
    dispatch_valid    = 1'b0;
  endtask

  task automatic comp(input logic [3:0] t, input logic [31:0] d);
    complete_valid = 1'b1;
    complete_tag   = t;
    complete_data  = d;
    tick();
    complete_valid = 1'b0;
  endtask

  initial begin
    int n_before;
    rst_n = 1'b1;
    dispatch_rw = 1'b0; dispatch_preg = '0; dispatch_al_index = '0;
    complete_tag = '0; complete_data = '0;
    quiet_retires = 0;
    @(negedge clk);
    do_reset();

    // ---- reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", dispatch_ready, 1);
    check("rst_we", wb_write_enable, 0);
    check("rst_wbaddr", wb_physical_write_addr, 0);
    check("rst_tag", dispatch_tag, 0);

    // ---- single instruction, complete, retire one edge later
    disp(1'b1, 6'd33, 5'd0);
    check("t1_count_disp", count, 1);
    comp(4'd0, 32'hDEADBEEF);
    check("t1_we_not_yet", wb_write_enable, 0);
    tick();
    check("t1_we", wb_write_enable, 1);
    check("t1_addr", wb_physical_write_addr, 33);
    check("t1_data", wb_physical_write_data, 32'hDEADBEEF);
    check("t1_al", wb_active_list_index, 0);
    check("t1_count", count, 0);
    tick();
    check("t1_we_drop", wb_write_enable, 0);
    check("t1_addr_hold", wb_physical_write_addr, 33);

    // ---- out-of-order completion, in-order retirement
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_tag%0d", i), dispatch_tag, i);
      disp(1'b1, 6'(40 + i), 5'(10 + i));
    end
    comp(4'd2, 32'hA2);
    check("t2_we_a", wb_write_enable, 0);
    comp(4'd0, 32'hA0);
    check("t2_we_b", wb_write_enable, 0);
    comp(4'd1, 32'hA1);
    check("t2_addr40", wb_physical_write_addr, 40);
    check("t2_we40", wb_write_enable, 1);
    check("t2_data40", wb_physical_write_data, 32'hA0);
    tick();
    check("t2_addr41", wb_physical_write_addr, 41);
    check("t2_we41", wb_write_enable, 1);
    check("t2_data41", wb_physical_write_data, 32'hA1);
    tick();
    check("t2_addr42", wb_physical_write_addr, 42);
    check("t2_al42", wb_active_list_index, 12);
    check("t2_data42", wb_physical_write_data, 32'hA2);
    tick();
    check("t2_we_end", wb_write_enable, 0);
    check("t2_empty", empty, 1);

    // ---- fill to full, 17th dispatch refused
    do_reset();
    for (int i = 0; i < 16; i++) disp(1'b1, 6'(i + 1), 5'(i));
    check("t3_count", count, 16);
    check("t3_full", full, 1);
    check("t3_ready", dispatch_ready, 0);
    check("t3_tag", dispatch_tag, 0);
    disp(1'b1, 6'd63, 5'd31);
    check("t3_count_17", count, 16);
    check("t3_tag_17", dispatch_tag, 0);
    check("t3_we", wb_write_enable, 0);

    // ---- wrap-around: 15 in, 14 out, 10 more in
    do_reset();
    wb_al_log.delete();
    wb_addr_log.delete();
    for (int i = 0; i < 15; i++) disp(1'b1, 6'(i + 1), 5'(i));
    for (int t = 0; t < 14; t++) comp(4'(t), 32'(t));
    tick();
    check("t4_count_mid", count, 1);
    for (int k = 0; k < 10; k++) disp(1'b1, 6'(16 + k), 5'(15 + k));
    check("t4_tail", dispatch_tag, 9);
    check("t4_count_11", count, 11);
    for (int k = 0; k < 11; k++) comp(4'((14 + k) % 16), 32'(100 + k));
    tick();
    check("t4_nwb", wb_al_log.size(), 25);
    for (int i = 0; i < 25 && i < wb_al_log.size(); i++) begin
      check($sformatf("t4_al%0d", i), wb_al_log[i], i);
      check($sformatf("t4_addr%0d", i), wb_addr_log[i], i + 1);
    end
    check("t4_empty", empty, 1);

    // ---- non-writing retirements: rw=0, and rw=1 with preg 0
    do_reset();
    n_before = wb_al_log.size();
    disp(1'b0, 6'd5, 5'd3);
    disp(1'b1, 6'd0, 5'd4);
    check("t5_we_rw0", wb_write_enable, 0);
    check("t5_al_rw0", wb_active_list_index, 3);
    check("t5_count", count, 1);
    comp(4'd1, 32'h1234);
    tick();
    check("t5_we_p0", wb_write_enable, 0);
    check("t5_al_p0", wb_active_list_index, 4);
    check("t5_data_p0", wb_physical_write_data, 32'h1234);
    check("t5_count_end", count, 0);
    check("t5_nwb", wb_al_log.size(), n_before);

    // ---- asynchronous reset mid-operation
    do_reset();
    disp(1'b1, 6'd7, 5'd7);
    disp(1'b1, 6'd8, 5'd8);
    rst_n = 1'b0;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_empty", empty, 1);
    rst_n = 1'b1;

    // ---- flush with coincident completion
    do_reset();
    for (int i = 0; i < 5; i++) disp(1'b1, 6'(50 + i), 5'(20 + i));
    check("t7_count5", count, 5);
    flush          = 1'b1;
    complete_valid = 1'b1;
    complete_tag   = 4'd0;
    complete_data  = 32'h55;
    #1;
    check("t7_ready_flush", dispatch_ready, 0);
    n_before = wb_al_log.size();
    tick();
    flush          = 1'b0;
    complete_valid = 1'b0;
    check("t7_count", count, 0);
    check("t7_empty", empty, 1);
    check("t7_we", wb_write_enable, 0);
    tick();
    tick();
    tick();
    check("t7_nwb", wb_al_log.size(), n_before);
    check("t7_tag0", dispatch_tag, 0);
    disp(1'b1, 6'd9, 5'd9);
    check("t7_count1", count, 1);
    check("t7_tag1", dispatch_tag, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
